// File: rtl/spi_reg_controller_pkg.sv
// Shared constants for the SPI command/register protocol: command byte layout,
// the status readback address and the default identification byte.
package spi_reg_controller_pkg;

    localparam int         RW_BIT          = 7;
    localparam int         ADDR_MSB        = 6;
    localparam logic [6:0] STATUS_ADDR     = 7'h7F;
    localparam logic [7:0] ID_BYTE_DEFAULT = 8'hA5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } parse_state_t;

    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return cmd[RW_BIT];
    endfunction

    function automatic logic [6:0] cmd_addr(input logic [7:0] cmd);
        return cmd[ADDR_MSB:0];
    endfunction

endpackage

// File: rtl/spi_reg_controller_if.sv
// Byte-level handshake between the SPI slave core and the register controller.
interface spi_reg_controller_if;

    logic       spi_cs;
    logic       spi_done;
    logic [7:0] spi_rx;
    logic [7:0] spi_tx;

    modport master (input spi_cs, input spi_done, input spi_rx, output spi_tx);
    modport slave  (output spi_cs, output spi_done, output spi_rx, input spi_tx);

endinterface

// File: rtl/spi_frame_detect.sv
// Turns the slave's done/cs pair into single-cycle completed-byte and
// aborted-frame events.
module spi_frame_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs,
    input  logic spi_done,
    output logic byte_ok,
    output logic byte_abort
);

    logic done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d <= 1'b1;
        end else begin
            done_d <= spi_done;
        end
    end

    // cs already high when done rises means the slave forced done on an aborted frame
    assign byte_ok    = spi_done & ~done_d & ~spi_cs;
    assign byte_abort = spi_done & ~done_d &  spi_cs;

endmodule

// File: rtl/spi_reg_controller.sv
// Command/register parser on top of the byte-wide SPI slave; owns the register
// file, the MISO byte preload and the inter-byte timeout.
//   state   | meaning
//   ST_IDLE | waiting for a command byte, MISO carries ID_BYTE
//   ST_DATA | shifting data bytes of the current word, bursting across words
module spi_reg_controller
    import spi_reg_controller_pkg::*;
#(
    parameter int         DW      = 16,
    parameter int         NREGS   = 4,
    parameter int         TIMEOUT = 50000,
    parameter logic [7:0] ID_BYTE = ID_BYTE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_reg_controller_if.master    spi,
    input  logic [DW-1:0]           status,
    output logic [NREGS*DW-1:0]     regs_flat,
    output logic                    reg_we,
    output logic [6:0]              reg_addr,
    output logic                    err
);

    localparam int NBYTES = DW / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int TW     = $clog2(TIMEOUT + 1);

    parse_state_t  state_q, state_d;
    logic          byte_ok, byte_abort;
    logic          rw_q;
    logic [6:0]    addr_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] asm_q, snap_q;
    logic [DW-1:0] regs_q [NREGS];
    logic [7:0]    tx_q;
    logic [TW-1:0] tmr_q;
    logic          err_q, reg_we_q;
    logic [6:0]    reg_addr_q;

    logic          last_byte, timeout_hit, take_snap;
    logic [6:0]    snap_addr;
    logic [DW-1:0] snap_word, asm_word;

    spi_frame_detect u_frame_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs     (spi.spi_cs),
        .spi_done   (spi.spi_done),
        .byte_ok    (byte_ok),
        .byte_abort (byte_abort)
    );

    function automatic logic in_range(input logic [6:0] a);
        return int'(a) < NREGS;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_byte   = (idx_q == IW'(NBYTES - 1));
        timeout_hit = (state_q == ST_DATA) && (tmr_q == TW'(1)) && !byte_ok;
        asm_word    = DW'({asm_q, spi.spi_rx});
        snap_addr   = (state_q == ST_IDLE) ? cmd_addr(spi.spi_rx) : addr_q + 7'd1;
        take_snap   = byte_ok && ((state_q == ST_IDLE) ? cmd_is_read(spi.spi_rx)
                                                       : (rw_q && last_byte));
        snap_word   = '0;
        if (in_range(snap_addr)) begin
            snap_word = regs_q[snap_addr[AW-1:0]];
        end else if (snap_addr == STATUS_ADDR) begin
            snap_word = status;
        end

        if (byte_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (byte_ok)     state_d = ST_DATA;
                ST_DATA: if (timeout_hit) state_d = ST_IDLE;
                default:                  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q       <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            snap_q     <= '0;
            tx_q       <= ID_BYTE;
            tmr_q      <= '0;
            err_q      <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_addr_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            reg_we_q <= 1'b0;
            if (byte_abort) begin
                err_q <= 1'b1;
                tx_q  <= ID_BYTE;
            end else if (byte_ok) begin
                tmr_q <= TW'(TIMEOUT);
                if (state_q == ST_IDLE) begin
                    rw_q   <= cmd_is_read(spi.spi_rx);
                    addr_q <= cmd_addr(spi.spi_rx);
                    idx_q  <= '0;
                    if (!cmd_is_read(spi.spi_rx)) tx_q <= ID_BYTE;
                end else begin
                    if (!rw_q) begin
                        asm_q <= asm_word;
                        if (last_byte && in_range(addr_q)) begin
                            regs_q[addr_q[AW-1:0]] <= asm_word;
                            reg_we_q               <= 1'b1;
                            reg_addr_q             <= addr_q;
                        end
                    end else if (!last_byte) begin
                        tx_q   <= snap_q[DW-1 -: 8];
                        snap_q <= snap_q << 8;
                    end
                    if (last_byte) begin
                        addr_q <= addr_q + 7'd1;
                        idx_q  <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                // snap_q keeps only the bytes still to be shifted out
                if (take_snap) begin
                    tx_q   <= snap_word[DW-1 -: 8];
                    snap_q <= snap_word << 8;
                    if (snap_addr == STATUS_ADDR) err_q <= 1'b0;
                end
            end else if (state_q == ST_DATA) begin
                if (timeout_hit) begin
                    tx_q <= ID_BYTE;
                    if (idx_q != '0) err_q <= 1'b1;
                end else if (tmr_q != '0) begin
                    tmr_q <= tmr_q - TW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DW +: DW] = regs_q[g];
    end

    assign spi.spi_tx = tx_q;
    assign reg_we     = reg_we_q;
    assign reg_addr   = reg_addr_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Randomized transaction-level bench for spi_reg_controller with a scoreboard
// for MISO bytes and register commits.
module tb_spi_reg_controller;

    localparam int         DW      = 16;
    localparam int         NREGS   = 4;
    localparam int         TIMEOUT = 64;
    localparam int         NB      = DW / 8;
    localparam logic [7:0] ID      = 8'hA5;

    typedef struct packed {
        logic [6:0]    a;
        logic [DW-1:0] d;
    } we_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_controller_if ifc ();

    logic [DW-1:0]       status;
    logic [NREGS*DW-1:0] regs_flat;
    logic                reg_we;
    logic [6:0]          reg_addr;
    logic                err;
    logic [DW-2:0]       shi;

    assign status = {shi, err};

    spi_reg_controller #(
        .DW(DW), .NREGS(NREGS), .TIMEOUT(TIMEOUT), .ID_BYTE(ID)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (ifc),
        .status    (status),
        .regs_flat (regs_flat),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .err       (err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  miso_q[$];
    we_t         we_q[$];
    logic [7:0]  bq[$];
    logic [DW-1:0] mregs [NREGS];
    logic        merr;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge ifc.spi_cs) begin
        if (miso_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL miso_unexpected: got %0h expected no frame", ifc.spi_tx);
        end else begin
            check("miso", 64'(ifc.spi_tx), 64'(miso_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        we_t e;
        if (rst_n && reg_we === 1'b1) begin
            if (we_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL reg_we_unexpected: got addr %0h expected no commit", reg_addr);
            end else begin
                e = we_q.pop_front();
                check("reg_addr", 64'(reg_addr), 64'(e.a));
                check("reg_data", 64'(regs_flat[int'(e.a)*DW +: DW]), 64'(e.d));
            end
        end
    end

    function automatic logic [DW-1:0] model_word(input logic [6:0] a);
        if (int'(a) < NREGS) return mregs[int'(a)];
        if (a == 7'h7F)      return {shi, merr};
        return '0;
    endfunction

    function automatic int gap();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 34)) : int'($urandom_range(0, 3));
    endfunction

    task automatic frame(input logic [7:0] mosi, input logic [7:0] exp_miso,
                         input bit abort, input int extra);
        miso_q.push_back(exp_miso);
        @(negedge clk);
        ifc.spi_cs   = 1'b0;
        ifc.spi_done = 1'b0;
        repeat (16) @(negedge clk);
        if (abort) begin
            ifc.spi_cs = 1'b1;
            @(negedge clk);
            ifc.spi_rx   = 8'($urandom);
            ifc.spi_done = 1'b1;
        end else begin
            ifc.spi_rx   = mosi;
            ifc.spi_done = 1'b1;
            @(negedge clk);
            ifc.spi_cs = 1'b1;
        end
        repeat (4 + extra) @(negedge clk);
    endtask

    task automatic post_check(input string tag);
        logic [NREGS*DW-1:0] packed_regs;
        for (int i = 0; i < NREGS; i++) packed_regs[i*DW +: DW] = mregs[i];
        check({tag, "_err"}, 64'(err), 64'(merr));
        check({tag, "_regs"}, 64'(regs_flat), 64'(packed_regs));
    endtask

    // Write transaction: command then the bytes in bq; abort_at selects a frame to abort (-1: none)
    task automatic do_write(input logic [6:0] addr, input int abort_at);
        logic [6:0]    a;
        logic [DW-1:0] acc;
        a   = addr;
        acc = '0;
        if (abort_at == 0) begin
            frame({1'b0, addr}, ID, 1'b1, 0);
            merr = 1'b1;
            return;
        end
        frame({1'b0, addr}, ID, 1'b0, gap());
        for (int j = 0; j < bq.size(); j++) begin
            acc = {acc[DW-9:0], bq[j]};
            if (abort_at == j + 1) begin
                frame(bq[j], ID, 1'b1, 0);
                merr = 1'b1;
                return;
            end
            if (j % NB == NB - 1) begin
                if (int'(a) < NREGS) begin
                    mregs[int'(a)] = acc;
                    we_q.push_back({a, acc});
                end
                a = a + 7'd1;
            end
            frame(bq[j], ID, 1'b0, gap());
        end
        repeat (TIMEOUT + 10) @(negedge clk);
        if (bq.size() % NB != 0) merr = 1'b1;
    endtask

    task automatic do_read(input logic [6:0] addr, input int nbytes, input int abort_at);
        logic [6:0]    a;
        logic [DW-1:0] w;
        logic [7:0]    exp;
        a = addr;
        if (abort_at == 0) begin
            frame({1'b1, addr}, ID, 1'b1, 0);
            merr = 1'b1;
            return;
        end
        w = model_word(a);
        if (a == 7'h7F) merr = 1'b0;
        frame({1'b1, addr}, ID, 1'b0, gap());
        for (int j = 0; j < nbytes; j++) begin
            exp = w[DW-1-8*(j%NB) -: 8];
            if (abort_at == j + 1) begin
                frame(8'($urandom), exp, 1'b1, 0);
                merr = 1'b1;
                return;
            end
            frame(8'($urandom), exp, 1'b0, gap());
            if (j % NB == NB - 1) begin
                a = a + 7'd1;
                w = model_word(a);
                if (a == 7'h7F) merr = 1'b0;
            end
        end
        repeat (TIMEOUT + 10) @(negedge clk);
        if (nbytes % NB != 0) merr = 1'b1;
    endtask

    initial begin
        logic [6:0] addr;
        int         nbytes, abort_at;
        logic [6:0] picks [8];
        picks = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'h7E, 7'h7F};

        ifc.spi_cs   = 1'b1;
        ifc.spi_done = 1'b1;
        ifc.spi_rx   = 8'h00;
        shi          = '0;
        merr         = 1'b0;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_tx", 64'(ifc.spi_tx), 64'(ID));
        check("rst_we", 64'(reg_we), 64'd0);
        check("rst_addr", 64'(reg_addr), 64'd0);
        post_check("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        bq = {8'h12, 8'h34};
        do_write(7'd1, -1);
        post_check("wr1");
        do_read(7'd1, 2, -1);
        post_check("rd1");

        bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_write(7'd3, -1);
        post_check("burst");

        bq = {8'h77};
        do_write(7'd0, 1);
        post_check("abort");
        do_read(7'd0, 2, -1);
        post_check("rd0");

        bq = {8'h55};
        do_write(7'd2, -1);
        post_check("tmo");
        shi = 15'h2ACE;
        do_read(7'h7F, 2, -1);
        post_check("status");

        for (int t = 0; t < 45; t++) begin
            shi    = 15'($urandom);
            addr   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : picks[$urandom_range(0, 7)];
            nbytes = $urandom_range(0, 6);
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nbytes)) : -1;
            bq = {};
            for (int k = 0; k < nbytes; k++) bq.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 0) do_write(addr, abort_at);
            else                           do_read(addr, nbytes, abort_at);
            post_check("rand");
        end

        bq = {8'hFE, 8'hDC};
        do_write(7'd0, -1);
        frame(8'h01, ID, 1'b0, 0);
        frame(8'h99, ID, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        merr = 1'b0;
        check("arst_tx", 64'(ifc.spi_tx), 64'(ID));
        check("arst_we", 64'(reg_we), 64'd0);
        check("arst_addr", 64'(reg_addr), 64'd0);
        post_check("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bq = {8'h56, 8'h78};
        do_write(7'd1, -1);
        do_read(7'd1, 2, -1);
        post_check("post_rst");

        repeat (5) @(negedge clk);
        check("we_q_empty", 64'(we_q.size()), 64'd0);
        check("miso_q_empty", 64'(miso_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_controller.md
Name: spi_reg_controller

Overview:
Sequences the byte-wide SPI slave (BC=8) into a command/register protocol for the stepper core. Detects completed vs aborted frames, parses a command byte plus DW/8 data bytes per word (MSB first), and owns a small register file exported to the step generators. Loads the slave's din before each frame with status or readback data, supports burst auto-increment, and recovers from host stalls via an inter-byte timeout.

Parameters:
DW, 16, register width in bits (multiple of 8, 8..32)
NREGS, 4, number of writable registers (addresses 0..NREGS-1)
TIMEOUT, 50000, clk cycles with no completed byte before the parser returns to IDLE
ID_BYTE, 8'hA5, byte shifted out during every command frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
spi_cs  in  1  chip select seen by the slave, active low
spi_done  in  1  slave done flag (0 during transfer, 1 when idle/complete)
spi_rx  in  8  slave dout, byte received
spi_tx  out  8  slave din, byte to shift out in the next frame
status  in  DW  live status word, readable at address 7'h7F
regs_flat  out  NREGS*DW  register file, reg i at [i*DW +: DW]
reg_we  out  1  one-cycle pulse when a register is committed
reg_addr  out  7  address of the committed register
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state IDLE, all regs 0, spi_tx=ID_BYTE, reg_we=0, reg_addr=0, err=0, byte index 0, timeout counter 0, done_d=1.
- Byte event: done_d registered each clk. byte_ok = spi_done & ~done_d & ~spi_cs. byte_abort = spi_done & ~done_d & spi_cs (slave forces done on cs rising mid-frame; spi_rx is stale).
- byte_abort: state -> IDLE, err <= 1, spi_tx <= ID_BYTE, no register write.
- IDLE, on byte_ok: cmd = spi_rx. bit7=1 read, bit7=0 write; addr = bit[6:0]. Go to DATA, idx = 0.
  - Read: snapshot word = regs[addr] if addr<NREGS, status if addr==7'h7F, else 0. spi_tx <= snapshot[DW-1 -: 8] on the next clk.
  - Write: spi_tx <= ID_BYTE.
- DATA, on byte_ok:
  - Write: shift spi_rx into assembly reg. On last byte (idx==DW/8-1): if addr<NREGS, regs[addr] <= assembled word and reg_we=1 with reg_addr=addr for exactly one clk; out-of-range writes are dropped silently (no reg_we).
  - Read: spi_tx <= next lower byte of snapshot. On last byte the next word is snapshotted at addr+1 and its MSB byte is loaded.
  - After the last byte: addr <= addr+1 (7-bit, wraps 7F->00), idx <= 0, stay in DATA (burst). Otherwise idx <= idx+1.
- Host rule: cs high >= 3 clk between frames; spi_tx is stable within 2 clk of byte_ok.
- Timeout: counter clears on byte_ok, counts in DATA, saturates. Reaching TIMEOUT -> IDLE, spi_tx <= ID_BYTE. err <= 1 only if idx!=0 (partial word).
- Reading address 7'h7F clears err in the same clk the snapshot is taken; the snapshot carries the pre-clear err value in status as wired externally.
- Simultaneous timeout and byte_ok: byte_ok wins, counter clears.
- rst_n assertion mid-word discards the partial word; no reg_we.

Decomposition:
- Shared package/header: command bit positions (RW bit 7, addr [6:0]), STATUS_ADDR=7'h7F, ID_BYTE default.
- One sub-module: spi_frame_detect (done/cs edge logic -> byte_ok, byte_abort). Parser, register file and timeout remain in spi_reg_controller.

Test Plan:
- Write reg1: frames 0x01, 0x12, 0x34 -> reg_we pulse once, reg_addr=1, regs_flat[31:16]=0x1234, spi_tx=0xA5 throughout.
- Read reg1 after write: frames 0x81, x, x -> MISO bytes 0xA5, 0x12, 0x34.
- Burst write at addr 3: 0x03, AA,BB, CC,DD -> reg3=0xAABB, then addr 4 >= NREGS so CCDD is dropped, only one reg_we.
- Abort: 0x00, then cs rises after 4 sck -> err=1, state IDLE; next 0x80,x,x returns reg0 unchanged.
- Timeout: 0x02, 0x55, then idle TIMEOUT clk -> IDLE, err=1, reg2 unchanged; 0xFF,x,x returns status and clears err.
- Async reset during DATA after 0x01,0x99 -> all outputs at reset values immediately, regs 0.
